dqsw_train_ctrl: RTL and testbench

Write-leveling (DQSW) training sequencer for one DDR3 byte lane. It drives the dynamic delay-line controls of the lane's DQSW training IOD (load, move, direction) and clears its eye-monitor flags. It sweeps the delay one tap at a time, samples the 2-bit DQ feedback returned by the IOD after a settle window, and stops on the first stable 0→1 transition. The block sits between the DDR3 PHY training FSM and the DQSW_DQSW270_TRAINING IOD, running in the FAB_CLK domain.

---
 rtl/dqsw_train_ctrl.sv | 111 +++++++++++
 tb/tb_dqsw_train_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dqsw_train_ctrl.sv
// dqsw_train_ctrl: DDR3 write-leveling sweep that steps the DQSW delay line until a stable 0->1 feedback transition
module dqsw_train_ctrl #(
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 4
) (
  input  logic       FAB_CLK,
  input  logic       RESET,
  input  logic       TRAIN_START,
  input  logic [1:0] RX_DATA,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR,
  output logic [7:0] TAP_COUNT
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, EVAL, STEP, DONE, ERROR} state_t;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLES - 1);
  localparam logic [7:0]  TAP_LAST    = 8'(MAX_TAPS - 1);
  state_t      state;
  logic [1:0]  rx_q;
  logic [15:0] cnt;
  logic        seen_zero, all_one, all_zero;
  assign DELAY_LINE_DIRECTION = 1'b1;
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state                   <= IDLE;
      rx_q                    <= 2'b00;
      cnt                     <= 16'd0;
      seen_zero               <= 1'b0;
      all_one                 <= 1'b0;
      all_zero                <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      TRAIN_BUSY              <= 1'b0;
      TRAIN_DONE              <= 1'b0;
      TRAIN_ERR               <= 1'b0;
      TAP_COUNT               <= 8'd0;
    end else begin
      rx_q                    <= RX_DATA;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      if (DELAY_LINE_OUT_OF_RANGE && (state == SETTLE || state == SAMPLE || state == EVAL)) begin
        state      <= ERROR;
        TRAIN_BUSY <= 1'b0;
        TRAIN_ERR  <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE, ERROR: if (TRAIN_START) begin
            state                   <= LOAD;
            DELAY_LINE_LOAD         <= 1'b1;
            EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
            TRAIN_BUSY              <= 1'b1;
            TRAIN_DONE              <= 1'b0;
            TRAIN_ERR               <= 1'b0;
            TAP_COUNT               <= 8'd0;
            seen_zero               <= 1'b0;
          end
          LOAD: begin
            state <= SETTLE;
            cnt   <= 16'd0;
          end
          SETTLE: begin
            cnt      <= cnt == SETTLE_LAST ? 16'd0 : cnt + 16'd1;
            state    <= cnt == SETTLE_LAST ? SAMPLE : SETTLE;
            all_one  <= 1'b1;
            all_zero <= 1'b1;
          end
          SAMPLE: begin
            cnt      <= cnt + 16'd1;
            state    <= cnt == SAMPLE_LAST ? EVAL : SAMPLE;
            all_one  <= all_one & (rx_q == 2'b11);
            all_zero <= all_zero & (rx_q == 2'b00);
          end
          EVAL: begin
            if (all_one && seen_zero) begin
              state      <= DONE;
              TRAIN_BUSY <= 1'b0;
              TRAIN_DONE <= 1'b1;
            end else begin
              if (all_zero)
                seen_zero <= 1'b1;
              if (TAP_COUNT == TAP_LAST) begin
                state      <= ERROR;
                TRAIN_BUSY <= 1'b0;
                TRAIN_ERR  <= 1'b1;
              end else begin
                state                   <= STEP;
                DELAY_LINE_MOVE         <= 1'b1;
                EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
              end
            end
          end
          STEP: begin
            state     <= SETTLE;
            cnt       <= 16'd0;
            TAP_COUNT <= TAP_COUNT == 8'd255 ? 8'd255 : TAP_COUNT + 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dqsw_train_ctrl.sv
// tb_dqsw_train_ctrl: directed bench with an IOD feedback model for the DQSW training sequencer
module tb_dqsw_train_ctrl;
  logic       FAB_CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       TRAIN_START = 1'b0;
  logic       oor = 1'b0;
  logic [1:0] rx;
  logic       load, move, dir, clr, busy, done, err;
  logic [7:0] tap;
  int vectors = 0;
  int miscompares = 0;
  int mode = 2;
  int iod_tap = 0;
  bit ph = 1'b0;
  int cyc = 0;
  int last_move = -1;
  int move_cnt = 0;
  always #5 FAB_CLK = ~FAB_CLK;
  dqsw_train_ctrl dut (
    .FAB_CLK(FAB_CLK),
    .RESET(RESET),
    .TRAIN_START(TRAIN_START),
    .RX_DATA(rx),
    .DELAY_LINE_OUT_OF_RANGE(oor),
    .DELAY_LINE_LOAD(load),
    .DELAY_LINE_MOVE(move),
    .DELAY_LINE_DIRECTION(dir),
    .EYE_MONITOR_CLEAR_FLAGS(clr),
    .TRAIN_BUSY(busy),
    .TRAIN_DONE(done),
    .TRAIN_ERR(err),
    .TAP_COUNT(tap)
  );
  function automatic logic [1:0] pat(int m, int t, bit p);
    case (m)
      0: return t < 37 ? 2'b00 : 2'b11;
      1: return t < 10 ? 2'b11 : (t < 20 ? 2'b00 : 2'b11);
      2: return 2'b00;
      default: return p ? 2'b01 : 2'b10;
    endcase
  endfunction
  assign rx = pat(mode, iod_tap, ph);
  always @(posedge FAB_CLK) begin
    ph <= ~ph;
    iod_tap <= load ? 0 : (move ? iod_tap + 1 : iod_tap);
  end
  task automatic check(string tag, int obs, int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(negedge FAB_CLK) begin
    cyc++;
    if (load)
      last_move = -1;
    if (load || move || clr) begin
      check("clr_coincide", int'(clr), int'(load | move));
      check("load_move_excl", int'(load & move), 0);
    end
    if (move) begin
      if (last_move >= 0)
        check("move_gap", cyc - last_move, 14);
      last_move = cyc;
      move_cnt++;
    end
  end
  task automatic check_reset_vals(string p);
    check({p, "_load"}, int'(load), 0);
    check({p, "_move"}, int'(move), 0);
    check({p, "_dir"}, int'(dir), 1);
    check({p, "_clr"}, int'(clr), 0);
    check({p, "_busy"}, int'(busy), 0);
    check({p, "_done"}, int'(done), 0);
    check({p, "_err"}, int'(err), 0);
    check({p, "_tap"}, int'(tap), 0);
  endtask
  task automatic start_run(int m);
    @(negedge FAB_CLK);
    mode = m;
    move_cnt = 0;
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    check("start_load", int'(load), 1);
    check("start_clr", int'(clr), 1);
    check("start_busy", int'(busy), 1);
    check("start_done_clr", int'(done), 0);
    check("start_err_clr", int'(err), 0);
    check("start_tap", int'(tap), 0);
  endtask
  task automatic wait_end(int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge FAB_CLK);
      n++;
    end
    if (!(done || err))
      check("end_timeout", 0, 1);
  endtask
  task automatic wait_moves(int target);
    int n = 0;
    int g = 0;
    while (n < target && g < 3000) begin
      @(negedge FAB_CLK);
      if (move)
        n++;
      g++;
    end
    if (n < target)
      check("move_timeout", n, target);
  endtask
  task automatic check_end(string p, int exp_done, int exp_tap);
    check({p, "_done"}, int'(done), exp_done);
    check({p, "_err"}, int'(err), 1 - exp_done);
    check({p, "_busy"}, int'(busy), 0);
    check({p, "_tap"}, int'(tap), exp_tap);
    check({p, "_moves"}, move_cnt, exp_tap);
  endtask
  initial begin
    repeat (3) @(negedge FAB_CLK);
    check_reset_vals("rst");
    RESET = 1'b0;
    @(negedge FAB_CLK);
    check_reset_vals("idle");
    start_run(0);
    wait_end(3000);
    check_end("edge37", 1, 37);
    start_run(1);
    wait_end(3000);
    check_end("edge20", 1, 20);
    start_run(2);
    wait_end(4000);
    check_end("zeros", 0, 127);
    start_run(0);
    wait_moves(5);
    @(negedge FAB_CLK);
    check("oor_settle_tap", int'(tap), 5);
    check("oor_settle_busy", int'(busy), 1);
    oor = 1'b1;
    @(negedge FAB_CLK);
    oor = 1'b0;
    check("oor_err", int'(err), 1);
    check("oor_busy", int'(busy), 0);
    check("oor_tap", int'(tap), 5);
    repeat (60) @(negedge FAB_CLK);
    check("oor_no_move", move_cnt, 5);
    check("oor_err_hold", int'(err), 1);
    start_run(3);
    wait_end(4000);
    check_end("alt", 0, 127);
    start_run(2);
    wait_moves(12);
    repeat (10) @(negedge FAB_CLK);
    check("rst_sample_busy", int'(busy), 1);
    check("rst_sample_tap", int'(tap), 12);
    RESET = 1'b1;
    @(negedge FAB_CLK);
    RESET = 1'b0;
    check_reset_vals("midrst");
    repeat (3) @(negedge FAB_CLK);
    check("midrst_no_move", move_cnt, 12);
    start_run(2);
    repeat (5) @(negedge FAB_CLK);
    check("restart_busy", int'(busy), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
